// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for one shared memory port, with registered request/latch path.
// Optional abort-on-timeout counter is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we0,
    input  logic             req1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             we1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] rdata,
    output logic             sel,
    output logic             busy,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY0 = 2'd1,
        S_BUSY1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             mem_req_q, mem_req_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             mem_we_q, mem_we_d;
    logic             pick1_c;
    logic             gnt0_c, gnt1_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err0_c, err1_c;
`else
    // TIMEOUT has no effect without the abort counter.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Arbitration in IDLE, completion (and optional abort) in BUSYx.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        pick1_c     = 1'b0;
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err0_c      = 1'b0;
        err1_c      = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // Port 1 wins only if port 0 is idle or port 0 was served last.
                pick1_c = req1 && !(req0 && last_q);
                if (req0 || req1) begin
                    state_d     = pick1_c ? S_BUSY1 : S_BUSY0;
                    sel_d       = pick1_c;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = pick1_c ? addr1 : addr0;
                    mem_wdata_d = pick1_c ? wdata1 : wdata0;
                    mem_we_d    = pick1_c ? we1 : we0;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            S_BUSY0, S_BUSY1: begin
                if (mem_ack) begin
                    gnt0_c    = (state_q == S_BUSY0);
                    gnt1_c    = (state_q == S_BUSY1);
                    last_d    = (state_q == S_BUSY1);
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LIMIT) begin
                    err0_c    = (state_q == S_BUSY0);
                    err1_c    = (state_q == S_BUSY1);
                    last_d    = (state_q == S_BUSY1);
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign gnt0      = gnt0_c;
    assign gnt1      = gnt1_c;
`ifdef ARB_TIMEOUT_EN
    assign err0      = err0_c;
    assign err1      = err1_c;
`else
    assign err0      = 1'b0;
    assign err1      = 1'b0;
`endif
    assign rdata     = mem_rdata;
    assign sel       = sel_q;
    assign busy      = (state_q != S_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants are queued as requests are issued
// and checked against each gnt pulse by a monitor.
module tb_mem_port_arbiter;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] RD_KEY = 32'hC0DE_0000;

    typedef struct {
        logic         port;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic         we;
        logic [W-1:0] rdata;
    } exp_t;

    logic         clk, rst;
    logic         req0, we0, req1, we1;
    logic [W-1:0] addr0, wdata0, addr1, wdata1;
    logic         gnt0, gnt1, err0, err1, sel, busy, mem_req, mem_we, mem_ack;
    logic [W-1:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic         ack_auto, ack_inject;
    logic [W-1:0] auto_data, inj_data;
    int           ack_delay;

    exp_t exp_q[$];
    int   n_cmp, n_err, gnt_seen;

    assign mem_ack   = ack_auto | ack_inject;
    assign mem_rdata = ack_inject ? inj_data : auto_data;

    mem_port_arbiter #(.WIDTH(W), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
        .rdata(rdata), .sel(sel), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input logic [W-1:0] a, input logic [W-1:0] wd,
                        input logic we, input logic [W-1:0] rd);
        exp_t e;
        e.port = port; e.addr = a; e.wdata = wd; e.we = we; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic wait_gnts(input int target, input int budget);
        int i;
        for (i = 0; i < budget && gnt_seen < target; i++) @(negedge clk);
        if (gnt_seen < target) check("gnt_wait_expired", W'(gnt_seen), W'(target));
    endtask

    // Memory model: acks ack_delay cycles after mem_req rises; -1 never acks.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        ack_auto  = 1'b0;
        auto_data = '0;
        forever begin
            tick();
            ack_auto = 1'b0;
            if (mem_req && !rst) begin
                if (ack_delay >= 0 && wait_cnt == ack_delay) begin
                    ack_auto  = 1'b1;
                    auto_data = mem_addr ^ RD_KEY;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Grant monitor: every gnt pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (gnt0 || gnt1)) begin
                check("gnt_exclusive", W'(gnt0 & gnt1), '0);
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt", W'({gnt1, gnt0}), '0);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt_port", W'(gnt1), W'(e.port));
                    check("gnt_sel", W'(sel), W'(e.port));
                    check("gnt_mem_addr", mem_addr, e.addr);
                    check("gnt_mem_we", W'(mem_we), W'(e.we));
                    if (e.we) check("gnt_mem_wdata", mem_wdata, e.wdata);
                    check("gnt_rdata", rdata, e.rdata);
                    check("gnt_no_err", W'({err1, err0}), '0);
                end
                gnt_seen++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

`ifdef ARB_TIMEOUT_EN
    task automatic timeout_case(input bit ack_at_limit);
        int base;
        base = gnt_seen;
        if (ack_at_limit) begin
            ack_delay = 15;
            push(1'b0, 32'h500, 32'h0, 1'b0, 32'h500 ^ RD_KEY);
        end else begin
            ack_delay = -1;
        end
        addr0 = 32'h500; we0 = 1'b0; req0 = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                check("to_busy_hold", W'({busy, err0, gnt0}), W'(3'b100));
                tick();
            end else if (ack_at_limit) begin
                check("to_ack_wins", W'({err0, gnt0}), W'(2'b01));
            end else begin
                check("to_err_pulse", W'({err0, gnt0, mem_req}), W'(3'b101));
            end
        end
        tick();
        req0 = 1'b0;
        @(negedge clk);
        check("to_idle_after", W'({busy, mem_req, err0}), '0);
        if (ack_at_limit) check("to_gnt_count", W'(gnt_seen - base), W'(1));
        ack_delay = -1;
    endtask
`endif

    initial begin
        n_cmp = 0; n_err = 0; gnt_seen = 0;
        rst = 1'b1;
        req0 = 1'b0; addr0 = '0; wdata0 = '0; we0 = 1'b0;
        req1 = 1'b0; addr1 = '0; wdata1 = '0; we1 = 1'b0;
        ack_inject = 1'b0; inj_data = '0; ack_delay = -1;

        // Reset values
        @(negedge clk);
        check("rst_ctrl", W'({busy, mem_req, sel, gnt0, gnt1, err0, err1, mem_we}), '0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        tick();
        rst = 1'b0;

        // mem_ack while idle is ignored
        ack_inject = 1'b1; inj_data = 32'hFFFF_0000;
        @(negedge clk);
        check("idle_ack_no_gnt", W'({gnt0, gnt1, busy}), '0);
        tick();
        ack_inject = 1'b0;
        @(negedge clk);
        check("idle_ack_no_req", W'({mem_req, busy}), '0);

        // Both ports requesting continuously: 0,1,0,1 starting with port 0 after reset
        ack_delay = 0;
        addr0 = 32'h1000; wdata0 = 32'hAAAA_0000; we0 = 1'b0;
        addr1 = 32'h2000; wdata1 = 32'h5555_1111; we1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 32'h1000, 32'hAAAA_0000, 1'b0, 32'h1000 ^ RD_KEY);
            push(1'b1, 32'h2000, 32'h5555_1111, 1'b1, 32'h2000 ^ RD_KEY);
        end
        tick();
        req0 = 1'b1; req1 = 1'b1;
        wait_gnts(4, 40);
        tick();
        req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        check("rr_idle_after", W'({busy, mem_req}), '0);
        check("rr_sb_empty", W'(exp_q.size()), '0);

        // Single read on port 0 with explicit ack data
        ack_delay = -1;
        push(1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'hDEAD_BEEF);
        addr0 = 32'h0000_0040; we0 = 1'b0; req0 = 1'b1;
        tick();
        @(negedge clk);
        check("rd_issue", W'({mem_req, sel, busy}), W'(3'b101));
        check("rd_mem_addr", mem_addr, 32'h40);
        tick();
        ack_inject = 1'b1; inj_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd_gnt0", W'({gnt0, gnt1}), W'(2'b10));
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        ack_inject = 1'b0; req0 = 1'b0;
        @(negedge clk);
        check("rd_idle_after", W'({busy, mem_req, sel}), '0);

        // Port 1 write; address change during BUSY must not reach mem_addr
        ack_delay = 3;
        push(1'b1, 32'h100, 32'h1234_5678, 1'b1, 32'h100 ^ RD_KEY);
        addr1 = 32'h100; wdata1 = 32'h1234_5678; we1 = 1'b1; req1 = 1'b1;
        tick();
        @(negedge clk);
        check("wr_issue", W'({mem_req, sel, mem_we}), W'(3'b111));
        check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        tick();
        addr1 = 32'h200;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                check("wr_addr_stable", mem_addr, 32'h100);
                seen = gnt1;
                if (!seen) tick();
            end
            if (!seen) check("wr_gnt_expired", W'(seen), W'(1));
        end
        tick();
        req1 = 1'b0; we1 = 1'b0;

        // Reset in the middle of a port 1 transfer
        ack_delay = -1;
        addr1 = 32'h300; req1 = 1'b1;
        tick();
        @(negedge clk);
        check("rst_mid_busy", W'({mem_req, sel, busy}), W'(3'b111));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_clear", W'({mem_req, busy, sel, gnt1}), '0);
        req1 = 1'b0;
        tick();
        rst = 1'b0;
        ack_delay = 1;
        push(1'b1, 32'h400, 32'h0, 1'b0, 32'h400 ^ RD_KEY);
        addr1 = 32'h400; req1 = 1'b1;
        wait_gnts(gnt_seen + 1, 20);
        tick();
        req1 = 1'b0;
        ack_delay = -1;

`ifdef ARB_TIMEOUT_EN
        timeout_case(1'b0);
        timeout_case(1'b1);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
